// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq_hz,
                                                    input int unsigned baud);
    return clk_freq_hz / baud;
  endfunction

  // 100 MHz / 115200 baud, truncated.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = calc_clks_per_bit(100_000_000, 115_200);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_rx_path.sv
// Receive half of the 8N1 UART: input synchroniser, RX FSM, byte/valid/error outputs.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 received,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 is_receiving,
  output logic                 recv_error
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      BitLast  = 3'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_sync_q;
  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 received_q, received_d;
  logic                 error_q, error_d;
  // Cleared by a framing error; a start bit is only honoured once the line has idled high.
  logic                 armed_q, armed_d;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX state register and output flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      received_q <= 1'b0;
      error_q    <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      received_q <= received_d;
      error_q    <= error_d;
      armed_q    <= armed_d;
    end
  end

  // RX next-state: centre-sample start, data and stop bits.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    received_d = 1'b0;
    error_d    = 1'b0;
    armed_d    = armed_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_sync_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          // Line back high at mid start bit is a glitch, not a frame.
          state_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_sync_q) begin
            byte_d     = shift_q;
            received_d = 1'b1;
          end else begin
            error_d = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign received     = received_q;
  assign recv_error   = error_q;
  assign rx_byte      = byte_q;
  assign is_receiving = (state_q != StIdle);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: inline TX serialiser plus the uart_rx_path receiver.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx,
  output logic                 received,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 is_receiving,
  output logic                 is_transmitting,
  output logic                 recv_error
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BitLast = 3'(DATA_BITS - 1);

  uart_state_e          tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_q, tx_d;

  // TX state register; the line output is registered so the pin never glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      tx_q       <= tx_d;
    end
  end

  // TX next-state and next line level.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    tx_d       = 1'b1;
    unique case (tx_state_q)
      StIdle: begin
        if (transmit) begin
          tx_state_d = StStart;
          tx_data_d  = tx_byte;
          tx_cnt_d   = '0;
        end
      end
      StStart: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = StData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BitLast) begin
            tx_bit_d   = '0;
            tx_state_d = StStop;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          // A strobe in the final stop cycle chains the next frame with no idle gap.
          if (transmit) begin
            tx_state_d = StStart;
            tx_data_d  = tx_byte;
          end else begin
            tx_state_d = StIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = StIdle;
    endcase

    unique case (tx_state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = tx_data_d[tx_bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx              = tx_q;
  assign is_transmitting = (tx_state_q != StIdle);

  uart_rx_path #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_path (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .received     (received),
    .rx_byte      (rx_byte),
    .is_receiving (is_receiving),
    .recv_error   (recv_error)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver at the default 868 clocks per bit.
module tb_uart_transceiver;

  localparam int CPB = 868;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       rx_bfm = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic       tx, received, is_receiving, is_transmitting, recv_error;
  logic [7:0] rx_byte;

  int n_total = 0;
  int n_pass  = 0;
  int n_rcv   = 0;
  int n_err   = 0;

  assign rx_line = loop_en ? tx : rx_bfm;

  always #5 clk = ~clk;

  uart_transceiver dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx_line),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .tx              (tx),
    .received        (received),
    .rx_byte         (rx_byte),
    .is_receiving    (is_receiving),
    .is_transmitting (is_transmitting),
    .recv_error      (recv_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
  endtask

  // Pulse counters; every valid pulse must coincide with is_receiving low.
  always @(negedge clk) begin
    if (received === 1'b1) begin
      n_rcv++;
      check("rx_idle_on_pulse", 32'(is_receiving), 32'd0);
    end
    if (recv_error === 1'b1) n_err++;
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Serial model: one 8N1 frame on rx, with a selectable stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_bfm = 1'b0;
    wait_cycles(CPB);
    for (int b = 0; b < 8; b++) begin
      rx_bfm = d[b];
      wait_cycles(CPB);
    end
    rx_bfm = stop;
    wait_cycles(CPB);
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] line;  // line[i] = i-th bit on the wire: start, d0..d7, stop
  } vec_t;

  vec_t       vecs[3];
  int         rcv0, err0, busy, bad;
  logic [9:0] cap;

  initial begin
    vecs[0] = '{data: 8'h00, line: 10'b10_0000_0000};
    vecs[1] = '{data: 8'hA5, line: 10'b11_0100_1010};
    vecs[2] = '{data: 8'h3C, line: 10'b10_0111_1000};

    // Reset state
    wait_cycles(5);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_is_tx", 32'(is_transmitting), 32'd0);
    check("rst_is_rx", 32'(is_receiving), 32'd0);
    check("rst_received", 32'(received), 32'd0);
    check("rst_recv_error", 32'(recv_error), 32'd0);
    check("rst_rx_byte", 32'(rx_byte), 32'h00);
    rst = 1'b1;
    wait_cycles(5);

    // Table: transmit each byte with rx looped back to tx
    loop_en = 1'b1;
    for (int v = 0; v < 3; v++) begin
      rcv0 = n_rcv;
      err0 = n_err;
      busy = 0;
      bad  = 0;
      cap  = '0;
      tx_byte  = vecs[v].data;
      transmit = 1'b1;
      @(negedge clk);
      transmit = 1'b0;
      for (int k = 0; k < 11 * CPB; k++) begin
        if (is_transmitting === 1'b1) busy++;
        if (k < 10 * CPB) begin
          if (tx !== vecs[v].line[k / CPB]) bad++;
          if (k % CPB == CPB / 2) cap[k / CPB] = tx;
        end else if (tx !== 1'b1) begin
          bad++;
        end
        @(negedge clk);
      end
      check("tx_frame_bits", 32'(cap), 32'(vecs[v].line));
      check("tx_cycle_exact", 32'(bad), 32'd0);
      check("tx_busy_cycles", 32'(busy), 32'(10 * CPB));
      check("loop_rx_pulses", 32'(n_rcv - rcv0), 32'd1);
      check("loop_rx_errors", 32'(n_err - err0), 32'd0);
      check("loop_rx_byte", 32'(rx_byte), 32'(vecs[v].data));
    end
    loop_en = 1'b0;
    wait_cycles(10);

    // Framing error: data 0xFF with stop bit low; rx_byte must keep 0x3C
    rcv0 = n_rcv;
    err0 = n_err;
    send_frame(8'hFF, 1'b0);
    rx_bfm = 1'b1;
    wait_cycles(2 * CPB);
    check("ferr_err_pulses", 32'(n_err - err0), 32'd1);
    check("ferr_no_received", 32'(n_rcv - rcv0), 32'd0);
    check("ferr_rx_byte_held", 32'(rx_byte), 32'h3C);
    check("ferr_rx_idle", 32'(is_receiving), 32'd0);

    // Clean 0x55 after the error
    rcv0 = n_rcv;
    err0 = n_err;
    send_frame(8'h55, 1'b1);
    wait_cycles(4);
    check("after_ferr_received", 32'(n_rcv - rcv0), 32'd1);
    check("after_ferr_errors", 32'(n_err - err0), 32'd0);
    check("after_ferr_rx_byte", 32'(rx_byte), 32'h55);
    wait_cycles(CPB);

    // Start glitch: 200 cycles low
    rcv0 = n_rcv;
    err0 = n_err;
    rx_bfm = 1'b0;
    wait_cycles(100);
    check("glitch_is_rx_mid", 32'(is_receiving), 32'd1);
    wait_cycles(100);
    rx_bfm = 1'b1;
    wait_cycles(CPB);
    check("glitch_is_rx_end", 32'(is_receiving), 32'd0);
    check("glitch_no_received", 32'(n_rcv - rcv0), 32'd0);
    check("glitch_no_error", 32'(n_err - err0), 32'd0);
    check("glitch_rx_byte_held", 32'(rx_byte), 32'h55);

    // Busy: a second strobe mid-frame is dropped
    cap = '0;
    tx_byte  = 8'h11;
    transmit = 1'b1;
    @(negedge clk);
    transmit = 1'b0;
    for (int k = 0; k < 11 * CPB; k++) begin
      if (k == 3 * CPB) begin
        tx_byte  = 8'h22;
        transmit = 1'b1;
      end else begin
        transmit = 1'b0;
      end
      if (k < 10 * CPB && k % CPB == CPB / 2) cap[k / CPB] = tx;
      @(negedge clk);
    end
    transmit = 1'b0;
    check("busy_frame_bits", 32'(cap), 32'(10'b10_0010_0010));
    check("busy_no_queue", 32'(is_transmitting), 32'd0);
    check("busy_line_idle", 32'(tx), 32'd1);

    // Reset in the middle of a frame
    tx_byte  = 8'h00;
    transmit = 1'b1;
    @(negedge clk);
    transmit = 1'b0;
    wait_cycles(3 * CPB);
    check("pre_rst_tx_low", 32'(tx), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_is_tx", 32'(is_transmitting), 32'd0);
    rst = 1'b1;
    wait_cycles(CPB);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_is_tx", 32'(is_transmitting), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
